// File: rtl/latch_bank_write_seq_if.sv
// Request/latch-control bundle for the operand latch write sequencer.
// master drives requests, slave (the sequencer) drives the latch controls.
interface latch_bank_write_seq_if #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   parameter int AW    = 2
);
   logic             wr_valid;
   logic             wr_ready;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             clr_req;
   logic             clr_ack;
   logic             busy;
   logic [WIDTH-1:0] lat_d;
   logic [NREGS-1:0] lat_gate;
   logic             lat_reset_b;

   modport master (
      output wr_valid, wr_addr, wr_data, clr_req,
      input  wr_ready, clr_ack, busy, lat_d, lat_gate, lat_reset_b
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, clr_req,
      output wr_ready, clr_ack, busy, lat_d, lat_gate, lat_reset_b
   );
endinterface

// File: rtl/latch_bank_write_seq.sv
// Write/clear sequencer producing registered, glitch-free D/GATE/RESET_B
// controls for a bank of level-sensitive operand latches.
module latch_bank_write_seq #(
   parameter int WIDTH       = 8,
   parameter int NREGS       = 4,
   parameter int AW          = 2,
   parameter int GATE_CYCLES = 1,
   parameter int HOLD_CYCLES = 1,
   parameter int CLR_CYCLES  = 2
) (
   input logic clk,
   input logic rst,
   latch_bank_write_seq_if.slave bus
);
   localparam int MAXGH = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
   localparam int MAXC  = (MAXGH > CLR_CYCLES) ? MAXGH : CLR_CYCLES;
   localparam int CW    = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_CLEAR, S_RECOVER
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic             from_rst_q, from_rst_d;
   logic [WIDTH-1:0] lat_d_q, lat_d_d;
   logic [NREGS-1:0] gate_q, gate_d;
   logic             rstb_q, rstb_d;
   logic             ready_q, ready_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;

   // Out-of-range addresses decode to no gate, so the write is silently dropped.
   function automatic logic [NREGS-1:0] decode(input logic [AW-1:0] a);
      logic [NREGS-1:0] g;
      g = '0;
      for (int i = 0; i < NREGS; i++)
         if (a == AW'(i)) g[i] = 1'b1;
      return g;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      from_rst_d = from_rst_q;
      lat_d_d    = lat_d_q;
      gate_d     = '0;
      rstb_d     = 1'b1;
      ready_d    = 1'b0;
      ack_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.clr_req) begin
               state_d    = S_CLEAR;
               cnt_d      = CW'(CLR_CYCLES - 1);
               from_rst_d = 1'b0;
               rstb_d     = 1'b0;
            end else if (bus.wr_valid && ready_q) begin
               // Data goes out a full cycle before the gate rises (setup).
               state_d = S_SETUP;
               addr_d  = bus.wr_addr;
               lat_d_d = bus.wr_data;
            end else begin
               ready_d = 1'b1;
            end
         end
         S_SETUP: begin
            state_d = S_PULSE;
            cnt_d   = CW'(GATE_CYCLES - 1);
            gate_d  = decode(addr_q);
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               cnt_d   = CW'(HOLD_CYCLES - 1);
            end else begin
               cnt_d  = cnt_q - 1'b1;
               gate_d = decode(addr_q);
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               ready_d = !bus.clr_req;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_CLEAR: begin
            if (cnt_q == '0) begin
               state_d = S_RECOVER;
               ack_d   = !from_rst_q;
            end else begin
               cnt_d  = cnt_q - 1'b1;
               rstb_d = 1'b0;
            end
         end
         S_RECOVER: begin
            state_d = S_IDLE;
            ready_d = !bus.clr_req;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_CLEAR;
         cnt_q      <= CW'(CLR_CYCLES - 1);
         addr_q     <= '0;
         from_rst_q <= 1'b1;
         lat_d_q    <= '0;
         gate_q     <= '0;
         rstb_q     <= 1'b0;
         ready_q    <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         from_rst_q <= from_rst_d;
         lat_d_q    <= lat_d_d;
         gate_q     <= gate_d;
         rstb_q     <= rstb_d;
         ready_q    <= ready_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.wr_ready    = ready_q;
   assign bus.clr_ack     = ack_q;
   assign bus.busy        = busy_q;
   assign bus.lat_d       = lat_d_q;
   assign bus.lat_gate    = gate_q;
   assign bus.lat_reset_b = rstb_q;
endmodule

// File: tb/tb_latch_bank_write_seq.sv
// Two sequencer instances (default timing; GATE=3/HOLD=2/NREGS=3) checked every
// cycle against a cycle-offset model, plus directed literal checks.
module tb_latch_bank_write_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_r    [2];
   logic       in_valid [2];
   logic [1:0] in_addr  [2];
   logic [7:0] in_data  [2];
   logic       in_clr   [2];

   latch_bank_write_seq_if #(.WIDTH(8), .NREGS(4), .AW(2)) b0 ();
   latch_bank_write_seq_if #(.WIDTH(8), .NREGS(3), .AW(2)) b1 ();

   latch_bank_write_seq #(.WIDTH(8), .NREGS(4), .AW(2), .GATE_CYCLES(1),
      .HOLD_CYCLES(1), .CLR_CYCLES(2)) u0 (.clk(clk), .rst(rst_r[0]), .bus(b0));
   latch_bank_write_seq #(.WIDTH(8), .NREGS(3), .AW(2), .GATE_CYCLES(3),
      .HOLD_CYCLES(2), .CLR_CYCLES(2)) u1 (.clk(clk), .rst(rst_r[1]), .bus(b1));

   assign b0.wr_valid = in_valid[0];
   assign b0.wr_addr  = in_addr[0];
   assign b0.wr_data  = in_data[0];
   assign b0.clr_req  = in_clr[0];
   assign b1.wr_valid = in_valid[1];
   assign b1.wr_addr  = in_addr[1];
   assign b1.wr_data  = in_data[1];
   assign b1.clr_req  = in_clr[1];

   logic [3:0] o_gate [2];
   logic [7:0] o_d    [2];
   logic       o_rb   [2];
   logic       o_rdy  [2];
   logic       o_ack  [2];
   logic       o_busy [2];
   assign o_gate[0] = b0.lat_gate;
   assign o_gate[1] = {1'b0, b1.lat_gate};
   assign o_d[0]    = b0.lat_d;
   assign o_d[1]    = b1.lat_d;
   assign o_rb[0]   = b0.lat_reset_b;
   assign o_rb[1]   = b1.lat_reset_b;
   assign o_rdy[0]  = b0.wr_ready;
   assign o_rdy[1]  = b1.wr_ready;
   assign o_ack[0]  = b0.clr_ack;
   assign o_ack[1]  = b1.clr_ack;
   assign o_busy[0] = b0.busy;
   assign o_busy[1] = b1.busy;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
   endtask

   // Model: an operation is a kind (0 idle, 1 write, 2 clear) plus the number
   // of cycles since the edge that started it; outputs follow from the offset.
   int  P_G [2] = '{1, 3};
   int  P_H [2] = '{1, 2};
   int  P_N [2] = '{4, 3};
   int  P_C [2] = '{2, 2};
   int  m_kind [2];
   int  m_age  [2];
   int  m_addr [2];
   logic [7:0] m_d [2];
   bit  m_fromrst [2];
   bit  m_lastclr [2];
   bit  started = 0;

   function automatic void exp_out(input int i, output logic [3:0] g, output logic rb,
                                   output logic rdy, output logic ack, output logic busy);
      g = '0; rb = 1'b1; rdy = 1'b0; ack = 1'b0; busy = 1'b1;
      case (m_kind[i])
         0: begin busy = 1'b0; rdy = !m_lastclr[i]; end
         1: if (m_age[i] >= 2 && m_age[i] <= 1 + P_G[i] && m_addr[i] < P_N[i])
               g = 4'(1 << m_addr[i]);
         default: if (m_age[i] <= P_C[i]) rb = 1'b0; else ack = !m_fromrst[i];
      endcase
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [3:0] g; logic rb, rdy, ack, busy;
         exp_out(i, g, rb, rdy, ack, busy);
         if (rst_r[i]) begin
            m_kind[i] = 2; m_age[i] = 1; m_fromrst[i] = 1; m_d[i] = '0;
         end else if (m_kind[i] == 0) begin
            if (in_clr[i]) begin
               m_kind[i] = 2; m_age[i] = 1; m_fromrst[i] = 0;
            end else if (in_valid[i] && rdy) begin
               m_kind[i] = 1; m_age[i] = 1; m_addr[i] = int'(in_addr[i]); m_d[i] = in_data[i];
            end
         end else begin
            m_age[i]++;
            if (m_kind[i] == 1 && m_age[i] > 1 + P_G[i] + P_H[i]) m_kind[i] = 0;
            if (m_kind[i] == 2 && m_age[i] > P_C[i] + 1) m_kind[i] = 0;
         end
         m_lastclr[i] = in_clr[i];
      end
      started = 1;
   end

   logic [3:0] p_gate [2];
   logic [7:0] p_d    [2];
   logic       p_rb   [2];

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            logic [3:0] g; logic rb, rdy, ack, busy;
            exp_out(i, g, rb, rdy, ack, busy);
            check($sformatf("gate%0d", i), 32'(o_gate[i]), 32'(g));
            check($sformatf("reset_b%0d", i), 32'(o_rb[i]), 32'(rb));
            check($sformatf("wr_ready%0d", i), 32'(o_rdy[i]), 32'(rdy));
            check($sformatf("clr_ack%0d", i), 32'(o_ack[i]), 32'(ack));
            check($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(busy));
            check($sformatf("lat_d%0d", i), 32'(o_d[i]), 32'(m_d[i]));
            check($sformatf("onehot%0d", i), 32'((o_gate[i] & (o_gate[i] - 4'd1)) == 4'd0), 32'd1);
            if (!o_rb[i] || !p_rb[i])
               check($sformatf("gate_vs_reset%0d", i), 32'(o_gate[i]), 32'd0);
            if (o_d[i] !== p_d[i] && o_rb[i])
               check($sformatf("d_stable%0d", i), 32'(o_gate[i] | p_gate[i]), 32'd0);
            if (o_busy[i])
               check($sformatf("ready_busy%0d", i), 32'(o_rdy[i]), 32'd0);
            p_gate[i] = o_gate[i];
            p_d[i]    = o_d[i];
            p_rb[i]   = o_rb[i];
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_r[i] = 1'b1; in_valid[i] = 1'b0; in_addr[i] = '0;
         in_data[i] = '0; in_clr[i] = 1'b0;
         p_gate[i] = '0; p_d[i] = '0; p_rb[i] = 1'b0;
      end
      step(3);
      check("rst_gate", 32'(b0.lat_gate), 32'd0);
      check("rst_busy", 32'(b0.busy), 32'd1);
      rst_r[0] = 1'b0; rst_r[1] = 1'b0;
      step(1);
      check("rel_rb_low", 32'(b0.lat_reset_b), 32'd0);
      step(1);
      check("recover_rb", 32'(b0.lat_reset_b), 32'd1);
      check("recover_ack", 32'(b0.clr_ack), 32'd0);
      check("recover_rdy", 32'(b0.wr_ready), 32'd0);
      step(1);
      check("idle_rdy", 32'(b0.wr_ready), 32'd1);

      // single write addr 2
      in_valid[0] = 1'b1; in_addr[0] = 2'd2; in_data[0] = 8'hA5;
      step(1);
      in_valid[0] = 1'b0;
      check("wr_d_T1", 32'(b0.lat_d), 32'hA5);
      check("wr_gate_T1", 32'(b0.lat_gate), 32'd0);
      step(1);
      check("wr_gate_T2", 32'(b0.lat_gate), 32'b0100);
      check("wr_rdy_T2", 32'(b0.wr_ready), 32'd0);
      step(1);
      check("wr_gate_T3", 32'(b0.lat_gate), 32'd0);
      check("wr_rdy_T3", 32'(b0.wr_ready), 32'd0);
      step(1);
      check("wr_rdy_T4", 32'(b0.wr_ready), 32'd1);

      // back-to-back writes with wr_valid held
      in_valid[0] = 1'b1; in_addr[0] = 2'd0; in_data[0] = 8'h11;
      step(1);
      in_addr[0] = 2'd3; in_data[0] = 8'h3C;
      step(3);
      check("b2b_d_T4", 32'(b0.lat_d), 32'h11);
      check("b2b_rdy_T4", 32'(b0.wr_ready), 32'd1);
      step(1);
      in_valid[0] = 1'b0;
      check("b2b_d_T5", 32'(b0.lat_d), 32'h3C);
      check("b2b_gate_T5", 32'(b0.lat_gate), 32'd0);
      step(1);
      check("b2b_gate_T6", 32'(b0.lat_gate), 32'b1000);
      step(2);

      // clear beats a simultaneous write
      in_clr[0] = 1'b1; in_valid[0] = 1'b1; in_addr[0] = 2'd1; in_data[0] = 8'h5A;
      step(1);
      check("clr_rb1", 32'(b0.lat_reset_b), 32'd0);
      check("clr_d_kept", 32'(b0.lat_d), 32'h3C);
      step(1);
      in_clr[0] = 1'b0;
      check("clr_rb2", 32'(b0.lat_reset_b), 32'd0);
      step(1);
      check("clr_ack", 32'(b0.clr_ack), 32'd1);
      step(1);
      check("clr_rdy", 32'(b0.wr_ready), 32'd1);
      step(1);
      in_valid[0] = 1'b0;
      check("clr_then_wr", 32'(b0.lat_d), 32'h5A);
      step(5);

      // instance 1: out-of-range address, then a 3-cycle gate
      in_valid[1] = 1'b1; in_addr[1] = 2'd3; in_data[1] = 8'h77;
      step(1);
      in_valid[1] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("oor_rdy", 32'(b1.wr_ready), 32'd0);
         check("oor_gate", 32'(b1.lat_gate), 32'd0);
         step(1);
      end
      check("oor_rdy_back", 32'(b1.wr_ready), 32'd1);
      in_valid[1] = 1'b1; in_addr[1] = 2'd1; in_data[1] = 8'h99;
      step(1);
      in_valid[1] = 1'b0;
      check("g3_setup", 32'(b1.lat_gate), 32'd0);
      step(1);
      for (int k = 0; k < 3; k++) begin
         check("g3_gate", 32'(b1.lat_gate), 32'b010);
         step(1);
      end
      check("g3_gate_off", 32'(b1.lat_gate), 32'd0);
      step(3);

      // reset during PULSE
      in_valid[0] = 1'b1; in_addr[0] = 2'd1; in_data[0] = 8'hC3;
      step(1);
      in_valid[0] = 1'b0;
      step(1);
      check("mid_gate_on", 32'(b0.lat_gate), 32'b0010);
      rst_r[0] = 1'b1;
      step(1);
      check("mid_gate_off", 32'(b0.lat_gate), 32'd0);
      check("mid_rb", 32'(b0.lat_reset_b), 32'd0);
      rst_r[0] = 1'b0;
      step(4);

      // randomized traffic on both instances
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 2; i++) begin
            in_valid[i] = ($urandom_range(0, 99) < 60);
            in_addr[i]  = 2'($urandom_range(0, 3));
            in_data[i]  = 8'($urandom);
            in_clr[i]   = ($urandom_range(0, 99) < 5);
            rst_r[i]    = ($urandom_range(0, 199) == 0);
         end
         step(1);
      end
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0; in_clr[i] = 1'b0; rst_r[i] = 1'b0;
      end
      step(10);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
